// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
    localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 pin synchroniser, falling-edge detect, 11-bit frame FSM and inactivity timeout.
// Parity is enforced only when PS2_PARITY_CHECK_EN is defined.
module ps2_frame_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       err
);
    import ps2_pkg::*;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic                   fall_q, fall_d;
    logic                   data_smp_q, data_smp_d;
    ps2_state_e             state_q, state_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [7:0]             shift_q, shift_d;
    logic [TW-1:0]          tmo_cnt_q, tmo_cnt_d;
    logic                   byte_valid_q, byte_valid_d;
    logic                   err_q, err_d;
    logic                   clk_s;
    logic                   timeout;
    logic                   parity_ok;

    assign clk_s   = clk_sync_q[SYNC_STAGES-1];
    assign timeout = (state_q != IDLE) && (tmo_cnt_q == TIMEOUT_MAX);

`ifdef PS2_PARITY_CHECK_EN
    logic parity_q, parity_d;

    always_comb begin
        parity_d = parity_q;
        if (fall_q && state_q == PARITY) begin
            parity_d = data_smp_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity_ok = ^{shift_q, parity_q};
`else
    assign parity_ok = 1'b1;
`endif

    always_comb begin
        clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        data_sync_d  = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        clk_prev_d   = clk_s;
        fall_d       = clk_prev_q & ~clk_s;
        data_smp_d   = data_sync_q[SYNC_STAGES-1];

        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        err_d        = 1'b0;

        // The counter only runs inside a frame and parks at its limit rather than wrapping.
        if (fall_q || state_q == IDLE) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != TIMEOUT_MAX) begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
        end else begin
            tmo_cnt_d = tmo_cnt_q;
        end

        if (timeout) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end else if (fall_q) begin
            case (state_q)
                IDLE: begin
                    if (!data_smp_q) begin
                        state_d   = DATA;
                        bit_idx_d = 3'd0;
                    end
                end
                DATA: begin
                    shift_d   = {data_smp_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: state_d = STOP;
                STOP: begin
                    state_d = IDLE;
                    if (data_smp_q && parity_ok) begin
                        byte_valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Synchronisers reset to the idle-high line level so reset release never fakes a fall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q   <= '1;
            data_sync_q  <= '1;
            clk_prev_q   <= 1'b1;
            fall_q       <= 1'b0;
            data_smp_q   <= 1'b1;
            state_q      <= IDLE;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            tmo_cnt_q    <= '0;
            byte_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            clk_sync_q   <= clk_sync_d;
            data_sync_q  <= data_sync_d;
            clk_prev_q   <= clk_prev_d;
            fall_q       <= fall_d;
            data_smp_q   <= data_smp_d;
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            tmo_cnt_q    <= tmo_cnt_d;
            byte_valid_q <= byte_valid_d;
            err_q        <= err_d;
        end
    end

    assign byte_valid = byte_valid_q;
    assign byte_data  = shift_q;
    assign err        = err_q;

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: folds E0/F0 prefixes into key events and queues them in a FWFT FIFO.
// Define PS2_PARITY_CHECK_EN to reject frames with bad parity.
module ps2_key_receiver #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            ps2_clk,
    input  logic                            ps2_data,
    output logic                            ev_valid,
    input  logic                            ev_ready,
    output logic [7:0]                      ev_code,
    output logic                            ev_break,
    output logic                            ev_ext,
    output logic                            frame_err,
    output logic                            overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);
    import ps2_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_err;

    ps2_frame_rx #(
        .SYNC_STAGES   (SYNC_STAGES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_valid(rx_valid),
        .byte_data (rx_byte),
        .err       (rx_err)
    );

    logic          ext_f_q, ext_f_d;
    logic          brk_f_q, brk_f_d;
    logic          push_q, push_d;
    ps2_event_t    push_ev_q, push_ev_d;
    ps2_event_t    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          full;
    logic          pop;
    logic          wr_en;
    ps2_event_t    head;

    always_comb begin
        ext_f_d   = ext_f_q;
        brk_f_d   = brk_f_q;
        push_d    = 1'b0;
        push_ev_d = push_ev_q;
        if (rx_err) begin
            ext_f_d = 1'b0;
            brk_f_d = 1'b0;
        end else if (rx_valid) begin
            if (rx_byte == PS2_EXT_PREFIX) begin
                ext_f_d = 1'b1;
            end else if (rx_byte == PS2_BRK_PREFIX) begin
                brk_f_d = 1'b1;
            end else begin
                push_d    = 1'b1;
                push_ev_d = {ext_f_q, brk_f_q, rx_byte};
                ext_f_d   = 1'b0;
                brk_f_d   = 1'b0;
            end
        end
    end

    // A push into a full FIFO still lands if the head leaves in the same cycle.
    always_comb begin
        full       = (count_q == CW'(FIFO_DEPTH));
        pop        = (count_q != '0) && ev_ready;
        wr_en      = push_q && (!full || pop);
        overflow_d = push_q && full && !pop;
        wr_ptr_d   = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_f_q    <= 1'b0;
            brk_f_q    <= 1'b0;
            push_q     <= 1'b0;
            push_ev_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            ext_f_q    <= ext_f_d;
            brk_f_q    <= brk_f_d;
            push_q     <= push_d;
            push_ev_q  <= push_ev_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_ev_q;
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign ev_valid   = (count_q != '0);
    assign ev_code    = ev_valid ? head.code : 8'h00;
    assign ev_break   = ev_valid ? head.brk : 1'b0;
    assign ev_ext     = ev_valid ? head.ext : 1'b0;
    assign frame_err  = rx_err;
    assign overflow   = overflow_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Self-checking bench for ps2_key_receiver: table vectors, corner sequences and a random run
// against a queue-based event model.
module tb_ps2_key_receiver;

    localparam int HALF = 10;
    localparam int TMO  = 50000;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       ev_valid;
    logic       ev_ready = 1'b0;
    logic [7:0] ev_code;
    logic       ev_break;
    logic       ev_ext;
    logic       frame_err;
    logic       overflow;
    logic [3:0] fifo_count;

    always #5 clk = ~clk;

    ps2_key_receiver dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_code   (ev_code),
        .ev_break  (ev_break),
        .ev_ext    (ev_ext),
        .frame_err (frame_err),
        .overflow  (overflow),
        .fifo_count(fifo_count)
    );

    int checks = 0;
    int failures = 0;
    int err_seen = 0;
    int ovf_seen = 0;
    int exp_err = 0;
    int exp_ovf = 0;
    logic [9:0] exp_q[$];
    bit m_ext = 1'b0;
    bit m_brk = 1'b0;
    bit rand_mode = 1'b0;
    bit ready_cmd = 1'b0;
    bit prev_err = 1'b0;
    bit prev_ovf = 1'b0;

    typedef struct {
        int         nb;
        logic [7:0] b0, b1, b2;
        int         bad_idx;
        bit         bad_par;
        bit         bad_stop;
        logic [3:0] exp_cnt;
        logic [7:0] exp_code;
        bit         exp_brk;
        bit         exp_ext;
        int         exp_errs;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference model: prefix folding, error flag clearing and an 8-deep lossy queue.
    function automatic void modelByte(input logic [7:0] b);
        if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (exp_q.size() >= 8) exp_ovf++;
            else exp_q.push_back({m_ext, m_brk, b});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endfunction

    function automatic void modelErr();
        m_ext = 1'b0;
        m_brk = 1'b0;
        exp_err++;
    endfunction

    always @(posedge clk) begin
        #1;
        ev_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_cmd;
    end

    always @(negedge clk) begin : monitor
        logic [9:0] e;
        if (!reset) begin
            if (frame_err) begin
                err_seen++;
                checkOutput("frame_err_width", {31'd0, prev_err}, 32'd0);
            end
            if (overflow) begin
                ovf_seen++;
                checkOutput("overflow_width", {31'd0, prev_ovf}, 32'd0);
            end
            if (ev_valid && ev_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_event actual=0x%0h expected=none",
                             {ev_ext, ev_break, ev_code});
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("event_order", {22'd0, ev_ext, ev_break, ev_code}, {22'd0, e});
                end
            end
        end
        prev_err = frame_err;
        prev_ovf = overflow;
    end

    task automatic ps2Bit(input logic v);
        ps2_data = v;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = (~^b) ^ bad_par;
        if (bad_stop || (PAR_EN && bad_par)) modelErr();
        else modelByte(b);
        ps2Bit(1'b0);
        for (int i = 0; i < 8; i++) ps2Bit(b[i]);
        ps2Bit(par);
        ps2Bit(~bad_stop);
        ps2_data = 1'b1;
        repeat (2 * HALF) @(posedge clk);
    endtask

    task automatic sendPartial(input int nbits);
        ps2Bit(1'b0);
        for (int i = 0; i < nbits; i++) ps2Bit(1'b1);
        ps2_data = 1'b1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        ready_cmd = 1'b1;
        @(negedge clk);
        while (fifo_count != 4'd0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, {28'd0, fifo_count}, 32'd0);
        ready_cmd = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin : watchdog
        #3000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] simulation hung");
    end

    initial begin
        int e0;
        logic [7:0] b;
        int r;

        vecs[0] = '{1, 8'h1C, 8'h00, 8'h00, -1, 1'b0, 1'b0, 4'd1, 8'h1C, 1'b0, 1'b0, 0};
        vecs[1] = '{2, 8'hF0, 8'h1C, 8'h00, -1, 1'b0, 1'b0, 4'd1, 8'h1C, 1'b1, 1'b0, 0};
        vecs[2] = '{3, 8'hE0, 8'hF0, 8'h75, -1, 1'b0, 1'b0, 4'd1, 8'h75, 1'b1, 1'b1, 0};
        vecs[3] = '{1, 8'h1C, 8'h00, 8'h00, -1, 1'b0, 1'b0, 4'd1, 8'h1C, 1'b0, 1'b0, 0};
        vecs[4] = '{1, 8'h1C, 8'h00, 8'h00, 0, 1'b1, 1'b0, PAR_EN ? 4'd0 : 4'd1,
                    PAR_EN ? 8'h00 : 8'h1C, 1'b0, 1'b0, PAR_EN ? 1 : 0};
        vecs[5] = '{1, 8'h1C, 8'h00, 8'h00, 0, 1'b0, 1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 1};
        vecs[6] = '{3, 8'hE0, 8'h33, 8'h1C, 1, 1'b0, 1'b1, 4'd1, 8'h1C, 1'b0, 1'b0, 1};
        vecs[7] = '{2, 8'hE0, 8'h5A, 8'h00, -1, 1'b0, 1'b0, 4'd1, 8'h5A, 1'b0, 1'b1, 0};

        repeat (5) @(posedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_ev_valid", {31'd0, ev_valid}, 32'd0);
        checkOutput("reset_ev_code", {24'd0, ev_code}, 32'd0);
        checkOutput("reset_ev_flags", {30'd0, ev_ext, ev_break}, 32'd0);
        checkOutput("reset_pulses", {30'd0, frame_err, overflow}, 32'd0);
        checkOutput("reset_fifo_count", {28'd0, fifo_count}, 32'd0);

        for (int v = 0; v < 8; v++) begin
            e0 = err_seen;
            for (int k = 0; k < vecs[v].nb; k++) begin
                b = (k == 0) ? vecs[v].b0 : (k == 1) ? vecs[v].b1 : vecs[v].b2;
                applyStimulus(b, (k == vecs[v].bad_idx) && vecs[v].bad_par,
                              (k == vecs[v].bad_idx) && vecs[v].bad_stop);
            end
            @(negedge clk);
            checkOutput($sformatf("v%0d_count", v), {28'd0, fifo_count}, {28'd0, vecs[v].exp_cnt});
            checkOutput($sformatf("v%0d_code", v), {24'd0, ev_code}, {24'd0, vecs[v].exp_code});
            checkOutput($sformatf("v%0d_break", v), {31'd0, ev_break}, {31'd0, vecs[v].exp_brk});
            checkOutput($sformatf("v%0d_ext", v), {31'd0, ev_ext}, {31'd0, vecs[v].exp_ext});
            checkOutput($sformatf("v%0d_errs", v), err_seen - e0, vecs[v].exp_errs);
            drain($sformatf("v%0d_drain", v));
        end

        e0 = err_seen;
        sendPartial(4);
        modelErr();
        repeat (TMO + 100) @(posedge clk);
        @(negedge clk);
        checkOutput("timeout_errs", err_seen - e0, 1);
        applyStimulus(8'h2B, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("timeout_next_count", {28'd0, fifo_count}, 32'd1);
        checkOutput("timeout_next_code", {24'd0, ev_code}, 32'h2B);
        drain("timeout_drain");

        e0 = ovf_seen;
        for (int i = 1; i <= 9; i++) applyStimulus(8'(i), 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("ovf_count", {28'd0, fifo_count}, 32'd8);
        checkOutput("ovf_pulses", ovf_seen - e0, 1);
        checkOutput("ovf_head", {24'd0, ev_code}, 32'h01);
        drain("ovf_drain");
        checkOutput("ovf_queue_empty", exp_q.size(), 0);

        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 99));
            b = 8'($urandom_range(1, 8'hDF));
            if (r < 12) applyStimulus(8'hE0, 1'b0, 1'b0);
            else if (r < 25) applyStimulus(8'hF0, 1'b0, 1'b0);
            else if (r < 32) applyStimulus(b, 1'b0, 1'b1);
            else if (r < 40) applyStimulus(b, 1'b1, 1'b0);
            else applyStimulus(b, 1'b0, 1'b0);
        end
        rand_mode = 1'b0;
        drain("rand_drain");
        checkOutput("rand_queue_empty", exp_q.size(), 0);

        applyStimulus(8'h11, 1'b0, 1'b0);
        applyStimulus(8'h22, 1'b0, 1'b0);
        e0 = err_seen;
        sendPartial(3);
        reset = 1'b1;
        exp_q.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midreset_count", {28'd0, fifo_count}, 32'd0);
        checkOutput("midreset_valid", {31'd0, ev_valid}, 32'd0);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        checkOutput("midreset_no_err", err_seen - e0, 0);
        applyStimulus(8'h1C, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("midreset_next_count", {28'd0, fifo_count}, 32'd1);
        checkOutput("midreset_next_code", {24'd0, ev_code}, 32'h1C);
        drain("midreset_drain");

        checkOutput("err_total", err_seen, exp_err);
        checkOutput("ovf_total", ovf_seen, exp_ovf);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
